vec_mac_feeder: RTL
===================

// Module: vec_mac_feeder
// PURPOSE
//  Operand streamer and result collector for vec_mac. Takes one command (two row base addresses, row size,
//  row count), reads operand words from two 1-cycle-latency SRAMs, and streams LANES-element chunks with
//  start held across rows. It zero-pads the final partial chunk of each row, captures one result per
//  mac_done, and reports completion. Sits between the controller/SRAMs and the vec_mac instance.
// PARAMETERS
//  WIDTH       16  element width (bits), signed
//  N           8   elements per MAC tree
//  NUM_MACS    2   MAC trees; LANES = NUM_MACS*N (=16) elements per chunk/memory word
//  ADDR_W      16  SRAM word-address width
//  DONE_TMO    64  max cycles in WAIT_DONE before error
// PORTS
//  clk            in   1                clock
//  rst            in   1                synchronous reset, active-low
//  cmd_valid      in   1                command valid
//  cmd_ready      out  1                high only in IDLE; accept on cmd_valid&&cmd_ready
//  cmd_base_a     in   ADDR_W           row-0 word address, operand A
//  cmd_base_b     in   ADDR_W           row-0 word address, operand B
//  cmd_row_size   in   32               elements per row
//  cmd_num_rows   in   16               rows in this command
//  cmd_done       out  1                1-cycle completion pulse
//  cmd_err        out  1                valid with cmd_done: timeout occurred
//  mem_rd_en      out  1                SRAM read strobe (both SRAMs)
//  mem_rd_addr_a  out  ADDR_W           A word address
//  mem_rd_addr_b  out  ADDR_W           B word address
//  mem_rd_data_a  in   LANES*WIDTH      A data, valid 1 cycle after mem_rd_en
//  mem_rd_data_b  in   LANES*WIDTH      B data, valid 1 cycle after mem_rd_en
//  vector_A       out  LANES*WIDTH      lane i at [i*WIDTH+:WIDTH] -> MAC i/N, position i%N
//  vector_B       out  LANES*WIDTH      same lane mapping as vector_A
//  vec_start      out  1                high on every cycle a valid chunk is driven
//  vec_row_size   out  32               latched cmd_row_size
//  mac_done       in   1                vec_mac row-complete strobe
//  mac_result     in   2*WIDTH          vec_mac result, sampled when mac_done=1
//  res_valid      out  1                1-cycle pulse per captured result
//  res_data       out  2*WIDTH          captured mac_result
//  res_row        out  16               row index of res_data (0-based)
// BEHAVIOUR
//  Reset (rst=0 at posedge): state=IDLE, all outputs 0, except cmd_ready=1 one cycle after reset is released.
//  Mid-command reset aborts the command immediately: no cmd_done, and the row/chunk counters clear.
//  CPR = ceil(row_size/LANES) chunks per row; row r of A occupies words base_a + r*CPR .. +CPR-1 (same for B).
//  Address arithmetic wraps modulo 2^ADDR_W.
//  FSM IDLE -> STREAM -> WAIT_DONE -> IDLE.
//  IDLE: accept cmd (cycle 0); latch all fields.
//    If row_size==0 or num_rows==0: cmd_done=1 in cycle 1, no reads, no vec_start; stay IDLE.
//  STREAM: read one word per cycle, starting in cycle 1, contiguously across rows, with no bubbles.
//    Read data is registered to vector_A/B, so chunk k is on the outputs in cycle 3+k.
//    vec_start=1 for exactly num_rows*CPR consecutive cycles.
//    On the last chunk of a row, lanes i >= row_size - (CPR-1)*LANES are forced to 0 on A and B.
//    When vec_start=0, vector_A/B are held at 0.
//    Enter WAIT_DONE the cycle after the last chunk is driven.
//  Row accounting: each mac_done (in STREAM or WAIT_DONE) registers mac_result into res_data.
//    In the same capture, res_row = rows_done and rows_done increments; res_valid pulses the next cycle.
//    mac_done in IDLE is ignored.
//  WAIT_DONE: when rows_done==num_rows, pulse cmd_done with cmd_err=0 and go to IDLE.
//    If DONE_TMO cycles elapse first, pulse cmd_done with cmd_err=1 and go to IDLE.
//    A mac_done coinciding with the final count completes normally.
//  A cmd_valid while busy is not accepted; the command must be held until cmd_ready.
// TESTING
//  1) row_size=16, rows=1, base_a=0x10: one chunk, vec_start=1 in cycle 3 only;
//     mac_done -> res_valid, res_row=0, cmd_done, cmd_err=0.
//  2) row_size=40, rows=2: 6 chunks, addresses base..base+5; chunks 2 and 5 have lanes 8..15 zero;
//     vec_start high 6 consecutive cycles.
//  3) row_size=0: cmd_done in cycle 1, mem_rd_en and vec_start never assert.
//  4) base_a=0xFFFF, row_size=32: reads at 0xFFFF then 0x0000.
//  5) mac_done never returned: after 64 cycles in WAIT_DONE, cmd_done=1 and cmd_err=1;
//     the next command is accepted normally.
//  6) rst=0 during STREAM of row 1: outputs 0 next cycle, no cmd_done;
//     a fresh command then streams from its own base.

Source files
------------

// File: rtl/vec_mac_feeder_if.sv
// Signal bundle between vec_mac_feeder and its controller, operand SRAMs and vec_mac instance.
// master is the feeder's view; slave is the view of everything around it.
interface vec_mac_feeder_if #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned N        = 8,
    parameter int unsigned NUM_MACS = 2,
    parameter int unsigned ADDR_W   = 16
);
    localparam int unsigned Lanes = NUM_MACS * N;

    // Command channel
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [ADDR_W-1:0]        cmd_base_a;
    logic [ADDR_W-1:0]        cmd_base_b;
    logic [31:0]              cmd_row_size;
    logic [15:0]              cmd_num_rows;
    logic                     cmd_done;
    logic                     cmd_err;

    // Operand SRAM read port (shared strobe)
    logic                     mem_rd_en;
    logic [ADDR_W-1:0]        mem_rd_addr_a;
    logic [ADDR_W-1:0]        mem_rd_addr_b;
    logic [Lanes*WIDTH-1:0]   mem_rd_data_a;
    logic [Lanes*WIDTH-1:0]   mem_rd_data_b;

    // vec_mac side
    logic [Lanes*WIDTH-1:0]   vector_A;
    logic [Lanes*WIDTH-1:0]   vector_B;
    logic                     vec_start;
    logic [31:0]              vec_row_size;
    logic                     mac_done;
    logic [2*WIDTH-1:0]       mac_result;

    // Result stream
    logic                     res_valid;
    logic [2*WIDTH-1:0]       res_data;
    logic [15:0]              res_row;

    modport master (
        input  cmd_valid, cmd_base_a, cmd_base_b, cmd_row_size, cmd_num_rows,
        input  mem_rd_data_a, mem_rd_data_b, mac_done, mac_result,
        output cmd_ready, cmd_done, cmd_err,
        output mem_rd_en, mem_rd_addr_a, mem_rd_addr_b,
        output vector_A, vector_B, vec_start, vec_row_size,
        output res_valid, res_data, res_row
    );

    modport slave (
        output cmd_valid, cmd_base_a, cmd_base_b, cmd_row_size, cmd_num_rows,
        output mem_rd_data_a, mem_rd_data_b, mac_done, mac_result,
        input  cmd_ready, cmd_done, cmd_err,
        input  mem_rd_en, mem_rd_addr_a, mem_rd_addr_b,
        input  vector_A, vector_B, vec_start, vec_row_size,
        input  res_valid, res_data, res_row
    );
endinterface

// File: rtl/vec_mac_feeder.sv
// Operand streamer and result collector for vec_mac: reads row chunks from two SRAMs, drives
// zero-padded LANES-wide vectors, captures one result per mac_done and reports completion.
module vec_mac_feeder #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned N        = 8,
    parameter int unsigned NUM_MACS = 2,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DONE_TMO = 64
) (
    input logic              clk,
    input logic              rst,
    vec_mac_feeder_if.master bus
);
    localparam int unsigned Lanes = NUM_MACS * N;
    localparam int unsigned DataW = Lanes * WIDTH;
    localparam int unsigned RemW  = $clog2(Lanes + 1);
    localparam int unsigned TmoW  = (DONE_TMO > 1) ? $clog2(DONE_TMO) : 1;

    typedef enum logic [1:0] {StIdle, StStream, StWaitDone} state_e;

    state_e state_q, state_d;

    logic              ready_en_q;
    logic [31:0]       row_size_q;
    logic [15:0]       num_rows_q;
    logic [31:0]       cpr_q;
    logic [RemW-1:0]   rem_q;
    logic [ADDR_W-1:0] ptr_a_q;
    logic [ADDR_W-1:0] ptr_b_q;
    logic [31:0]       chunk_q;
    logic [15:0]       row_q;
    logic              rd_active_q;
    logic              p1_valid_q;
    logic              p1_last_q;
    logic              vec_start_q;
    logic [DataW-1:0]  vec_a_q;
    logic [DataW-1:0]  vec_b_q;
    logic [15:0]       rows_done_q;
    logic              res_valid_q;
    logic [2*WIDTH-1:0] res_data_q;
    logic [15:0]       res_row_q;
    logic              done_q;
    logic              err_q;
    logic [TmoW-1:0]   tmo_q;

    logic              cmd_ready;
    logic              accept;
    logic              cmd_empty;
    logic [31:0]       row_mod;
    logic [31:0]       cpr_d;
    logic [RemW-1:0]   rem_d;
    logic              rd_en;
    logic              rd_last_chunk;
    logic              rd_last;
    logic              mac_cap;
    logic [15:0]       rows_next;
    logic              all_rows;
    logic              tmo_hit;
    logic              wait_exit;
    logic [DataW-1:0]  lane_mask;

    // Command decode: chunks per row and the number of live lanes in a row's last chunk.
    assign accept    = bus.cmd_valid && cmd_ready;
    assign cmd_empty = (bus.cmd_row_size == '0) || (bus.cmd_num_rows == '0);
    assign row_mod   = bus.cmd_row_size % Lanes;
    assign cpr_d     = (bus.cmd_row_size / Lanes) + {31'd0, row_mod != '0};
    assign rem_d     = (row_mod == '0) ? RemW'(Lanes) : RemW'(row_mod);

    assign rd_en         = (state_q == StStream) && rd_active_q;
    assign rd_last_chunk = (chunk_q == cpr_q - 32'd1);
    assign rd_last       = rd_last_chunk && (row_q == num_rows_q - 16'd1);

    assign mac_cap   = bus.mac_done && (state_q != StIdle);
    assign rows_next = rows_done_q + 16'(mac_cap);
    assign all_rows  = (rows_done_q == num_rows_q) || (mac_cap && (rows_next == num_rows_q));
    assign tmo_hit   = (tmo_q == TmoW'(DONE_TMO - 1));
    assign wait_exit = all_rows || tmo_hit;

    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < int'(Lanes); i++) begin
            if (!p1_last_q || (i < int'(rem_q))) begin
                lane_mask[i*WIDTH +: WIDTH] = '1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept && !cmd_empty) begin
                    state_d = StStream;
                end
            end
            StStream: begin
                // Leave once every read has been issued and its data has reached the outputs.
                if (!rd_active_q && !p1_valid_q) begin
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (wait_exit) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cmd_ready         = (state_q == StIdle) && ready_en_q;
        bus.cmd_ready     = cmd_ready;
        bus.mem_rd_en     = rd_en;
        bus.mem_rd_addr_a = rd_en ? ptr_a_q : '0;
        bus.mem_rd_addr_b = rd_en ? ptr_b_q : '0;
        bus.vector_A      = vec_a_q;
        bus.vector_B      = vec_b_q;
        bus.vec_start     = vec_start_q;
        bus.vec_row_size  = row_size_q;
        bus.res_valid     = res_valid_q;
        bus.res_data      = res_data_q;
        bus.res_row       = res_row_q;
        bus.cmd_done      = done_q;
        bus.cmd_err       = err_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ready_en_q  <= 1'b0;
            row_size_q  <= '0;
            num_rows_q  <= '0;
            cpr_q       <= '0;
            rem_q       <= '0;
            ptr_a_q     <= '0;
            ptr_b_q     <= '0;
            chunk_q     <= '0;
            row_q       <= '0;
            rd_active_q <= 1'b0;
            p1_valid_q  <= 1'b0;
            p1_last_q   <= 1'b0;
            vec_start_q <= 1'b0;
            vec_a_q     <= '0;
            vec_b_q     <= '0;
            rows_done_q <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_row_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            tmo_q       <= '0;
        end else begin
            ready_en_q  <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            res_valid_q <= 1'b0;

            if (accept) begin
                row_size_q  <= bus.cmd_row_size;
                num_rows_q  <= bus.cmd_num_rows;
                cpr_q       <= cpr_d;
                rem_q       <= rem_d;
                ptr_a_q     <= bus.cmd_base_a;
                ptr_b_q     <= bus.cmd_base_b;
                chunk_q     <= '0;
                row_q       <= '0;
                rows_done_q <= '0;
                rd_active_q <= !cmd_empty;
                done_q      <= cmd_empty;
            end

            // Rows are contiguous in memory, so one running pointer per SRAM suffices.
            if (rd_en) begin
                ptr_a_q <= ptr_a_q + ADDR_W'(1);
                ptr_b_q <= ptr_b_q + ADDR_W'(1);
                if (rd_last_chunk) begin
                    chunk_q <= '0;
                    row_q   <= row_q + 16'd1;
                end else begin
                    chunk_q <= chunk_q + 32'd1;
                end
                if (rd_last) begin
                    rd_active_q <= 1'b0;
                end
            end

            p1_valid_q  <= rd_en;
            p1_last_q   <= rd_en && rd_last_chunk;
            vec_start_q <= p1_valid_q;
            vec_a_q     <= p1_valid_q ? (bus.mem_rd_data_a & lane_mask) : '0;
            vec_b_q     <= p1_valid_q ? (bus.mem_rd_data_b & lane_mask) : '0;

            if (mac_cap) begin
                res_data_q  <= bus.mac_result;
                res_row_q   <= rows_done_q;
                rows_done_q <= rows_next;
                res_valid_q <= 1'b1;
            end

            if (state_q == StWaitDone) begin
                tmo_q <= tmo_q + TmoW'(1);
                if (wait_exit) begin
                    done_q <= 1'b1;
                    err_q  <= !all_rows;
                end
            end else begin
                tmo_q <= '0;
            end
        end
    end
endmodule
